// File: rtl/i2c_target_responder_if.sv
// Bus and host-port bundle for the two-wire target responder.
// master: initiator/host side (drives scl, sda_in, host writes); slave: the responder.
interface i2c_target_responder_if;
  logic        scl;
  logic        sda_in;
  logic        sda_oe;
  logic [7:0]  data;
  logic        write;
  logic [3:0]  addin;
  logic [31:0] rxOut;
  logic        rxValid;
  logic        busy;
  logic        genCall;

  modport master (
    output scl, sda_in, data, write, addin,
    input  sda_oe, rxOut, rxValid, busy, genCall
  );

  modport slave (
    input  scl, sda_in, data, write, addin,
    output sda_oe, rxOut, rxValid, busy, genCall
  );
endinterface

// File: rtl/i2c_target_responder.sv
// Two-wire target responder: oversamples scl/sda, detects START/STOP, matches a
// 7-bit address, assembles 4-byte write words and returns a host-loaded read word.
// Optional feature macro: GENERAL_CALL_EN (address byte 8'h00 accepted as a write
// general call, flagged on genCall). Without it genCall is held 0.
module i2c_target_responder #(
  parameter logic [6:0] DEV_ADDR_RST = 7'h50,
  parameter int         SYNC_STAGES  = 2
) (
  input logic                   clk,
  input logic                   reset,
  i2c_target_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_s, sda_s, scl_d, sda_d;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  logic [6:0]  dev_addr;
  logic [31:0] rd_word;

  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [2:0]  byte_cnt, byte_cnt_n;
  logic [7:0]  rx_sh, rx_sh_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic [7:0]  rd_sel;
  logic [31:0] rx_word, rx_word_n;
  logic [31:0] rx_out, rx_out_n;
  logic        ack_bit, ack_bit_n;
  logic        oe, oe_n;
  logic        rx_valid, rx_valid_n;
  logic        busy_r, busy_n;
  logic        gc_r, gc_n;
  logic        addr_ok, gc_hit;

  // Byte n of the read word, MSB byte first; anything past the fourth reads as all ones.
  function automatic logic [7:0] rd_byte(input logic [31:0] w, input logic [2:0] n);
    case (n)
      3'd0:    rd_byte = w[31:24];
      3'd1:    rd_byte = w[23:16];
      3'd2:    rd_byte = w[15:8];
      3'd3:    rd_byte = w[7:0];
      default: rd_byte = 8'hFF;
    endcase
  endfunction

  // Synchronise scl/sda and keep one extra delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;
  assign rd_sel    = rd_byte(rd_word, byte_cnt);

  // Host register writes; they land immediately, even mid-transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      dev_addr <= DEV_ADDR_RST;
      rd_word  <= '0;
    end else if (bus.write) begin
      case (bus.addin)
        4'd0:    dev_addr       <= bus.data[6:0];
        4'd1:    rd_word[31:24] <= bus.data;
        4'd2:    rd_word[23:16] <= bus.data;
        4'd3:    rd_word[15:8]  <= bus.data;
        4'd4:    rd_word[7:0]   <= bus.data;
        default: ;
      endcase
    end
  end

  // Address decode of the received address byte (7-bit address plus R/W in bit 0).
  always_comb begin
    addr_ok = 1'b0;
    gc_hit  = 1'b0;
`ifdef GENERAL_CALL_EN
    if (rx_sh == 8'h00) begin
      addr_ok = 1'b1;
      gc_hit  = 1'b1;
    end else if (rx_sh[7:1] == 7'd0) begin
      addr_ok = 1'b0;
    end else begin
      addr_ok = (rx_sh[7:1] == dev_addr);
    end
`else
    addr_ok = (rx_sh[7:1] == dev_addr);
`endif
  end

  // State register and all transfer-tracking registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      rx_sh    <= '0;
      tx_sh    <= '0;
      rx_word  <= '0;
      rx_out   <= '0;
      ack_bit  <= 1'b0;
      oe       <= 1'b0;
      rx_valid <= 1'b0;
      busy_r   <= 1'b0;
      gc_r     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
      rx_sh    <= rx_sh_n;
      tx_sh    <= tx_sh_n;
      rx_word  <= rx_word_n;
      rx_out   <= rx_out_n;
      ack_bit  <= ack_bit_n;
      oe       <= oe_n;
      rx_valid <= rx_valid_n;
      busy_r   <= busy_n;
      gc_r     <= gc_n;
    end
  end

  // Next-state logic: bits are taken on scl rise, sda drive changes only on scl fall.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;
    rx_sh_n    = rx_sh;
    tx_sh_n    = tx_sh;
    rx_word_n  = rx_word;
    rx_out_n   = rx_out;
    ack_bit_n  = ack_bit;
    oe_n       = oe;
    rx_valid_n = 1'b0;
    busy_n     = busy_r;
    gc_n       = gc_r;

    if (stop_det) begin
      state_n    = IDLE;
      bit_cnt_n  = '0;
      byte_cnt_n = '0;
      oe_n       = 1'b0;
      busy_n     = 1'b0;
      gc_n       = 1'b0;
    end else if (start_det) begin
      // Fresh or repeated START: drop any partial word and re-arm address capture.
      state_n    = ADDR;
      bit_cnt_n  = '0;
      byte_cnt_n = '0;
      rx_word_n  = '0;
      oe_n       = 1'b0;
      gc_n       = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            rx_sh_n   = {rx_sh[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = '0;
            if (addr_ok) begin
              state_n = ADDR_ACK;
              oe_n    = 1'b1;
              busy_n  = 1'b1;
              gc_n    = gc_hit;
            end else begin
              state_n = IGNORE;
              busy_n  = 1'b0;
              gc_n    = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rx_sh[0]) begin
              state_n    = RD_BYTE;
              tx_sh_n    = rd_sel;
              oe_n       = ~rd_sel[7];
              byte_cnt_n = 3'd1;
            end else begin
              state_n = WR_BYTE;
              oe_n    = 1'b0;
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise) begin
            rx_sh_n   = {rx_sh[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = '0;
            if (byte_cnt < 3'd4) begin
              rx_word_n  = {rx_word[23:0], rx_sh};
              byte_cnt_n = byte_cnt + 3'd1;
              state_n    = WR_ACK;
              oe_n       = 1'b1;
            end else begin
              state_n = IGNORE;
              oe_n    = 1'b0;
              busy_n  = 1'b0;
              gc_n    = 1'b0;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_n = WR_BYTE;
            oe_n    = 1'b0;
            if (byte_cnt == 3'd4) begin
              rx_out_n   = rx_word;
              rx_valid_n = 1'b1;
            end
          end
        end
        RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_n   = RD_ACK;
              oe_n      = 1'b0;
              bit_cnt_n = '0;
            end else begin
              oe_n    = ~tx_sh[6];
              tx_sh_n = {tx_sh[6:0], 1'b1};
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            ack_bit_n = sda_s;
          end else if (scl_fall) begin
            if (!ack_bit) begin
              state_n = RD_BYTE;
              tx_sh_n = rd_sel;
              oe_n    = ~rd_sel[7];
              if (byte_cnt < 3'd5) byte_cnt_n = byte_cnt + 3'd1;
            end else begin
              state_n = IGNORE;
              oe_n    = 1'b0;
              busy_n  = 1'b0;
              gc_n    = 1'b0;
            end
          end
        end
        IGNORE: oe_n = 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.sda_oe  = oe;
  assign bus.rxOut   = rx_out;
  assign bus.rxValid = rx_valid;
  assign bus.busy    = busy_r;
  assign bus.genCall = gc_r;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench for i2c_target_responder: drives the initiator side of the
// open-drain link and the host register port, and checks responses.
module tb_i2c_target_responder;
  localparam int Q = 8;
  localparam int H = 2;

  logic clk = 1'b0;
  logic reset;
  logic sda_m;
  int   checks = 0;
  int   errors = 0;
  int   rxv_cnt = 0;
  int   oe_cnt = 0;

  logic [7:0] wr4 [4];
  logic [7:0] rd4 [4];

  i2c_target_responder_if bus();

  i2c_target_responder #(.DEV_ADDR_RST(7'h50), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.sda_in = sda_m & ~bus.sda_oe;

  // Count rxValid pulses and cycles in which the target pulls sda.
  always @(negedge clk) begin
    if (bus.rxValid === 1'b1) rxv_cnt++;
    if (bus.sda_oe === 1'b1) oe_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_cycle(input logic b, output logic s);
    wait_clk(H);
    sda_m = b;
    wait_clk(Q);
    bus.scl = 1'b1;
    wait_clk(Q / 2);
    s = bus.sda_in;
    wait_clk(Q / 2);
    bus.scl = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b0;
    wait_clk(Q);
    bus.scl = 1'b0;
  endtask

  task automatic i2c_rstart();
    wait_clk(H);
    sda_m = 1'b1;
    wait_clk(Q);
    bus.scl = 1'b1;
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(Q);
    bus.scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(H);
    sda_m = 1'b0;
    wait_clk(Q);
    bus.scl = 1'b1;
    wait_clk(Q);
    sda_m = 1'b1;
    wait_clk(Q);
  endtask

  task automatic send_bits(input logic [7:0] v);
    logic d;
    for (int i = 7; i >= 0; i--) bus_cycle(v[i], d);
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    send_bits(v);
    bus_cycle(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic nack);
    logic d;
    for (int i = 7; i >= 0; i--) bus_cycle(1'b1, v[i]);
    bus_cycle(nack, d);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    bus.addin = a;
    bus.data  = d;
    bus.write = 1'b1;
    wait_clk(1);
    bus.write = 1'b0;
  endtask

  initial begin
    logic       ack;
    logic       nacks;
    logic [7:0] rb;
    int         base_rxv;
    int         base_oe;

    wr4 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    rd4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.scl   = 1'b1;
    bus.data  = 8'h00;
    bus.write = 1'b0;
    bus.addin = 4'h0;
    sda_m     = 1'b1;
    reset     = 1'b1;
    wait_clk(4);

    // Reset state
    check("rst_sda_oe",  32'(bus.sda_oe), 0);
    check("rst_rxout",   bus.rxOut, 0);
    check("rst_rxvalid", 32'(bus.rxValid), 0);
    check("rst_busy",    32'(bus.busy), 0);
    check("rst_gencall", 32'(bus.genCall), 0);
    reset = 1'b0;

    // Idle bus
    base_oe = oe_cnt;
    wait_clk(100);
    check("idle_sda_oe",  oe_cnt - base_oe, 0);
    check("idle_rxvalid", rxv_cnt, 0);
    check("idle_rxout",   bus.rxOut, 0);

    // Reset while the target holds the address ACK
    i2c_start();
    send_bits(8'hA0);
    wait_clk(5);
    check("pre_rst_ack_drive", 32'(bus.sda_oe), 1);
    reset = 1'b1;
    wait_clk(1);
    check("mid_rst_sda_oe", 32'(bus.sda_oe), 0);
    check("mid_rst_busy",   32'(bus.busy), 0);
    reset = 1'b0;
    bus.scl = 1'b1;
    wait_clk(Q);
    sda_m = 1'b1;
    wait_clk(Q);

    // Full 4-byte write
    base_rxv = rxv_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check("wr_addr_ack", 32'(ack), 0);
    check("wr_busy",     32'(bus.busy), 1);
    nacks = 1'b0;
    for (int i = 0; i < 4; i++) begin
      write_byte(wr4[i], ack);
      nacks |= ack;
    end
    check("wr_data_acks", 32'(nacks), 0);
    wait_clk(Q);
    check("wr_rxvalid_pulse", rxv_cnt - base_rxv, 1);
    check("wr_rxout", bus.rxOut, 32'hDEADBEEF);
    i2c_stop();
    wait_clk(4);
    check("wr_busy_after_stop", 32'(bus.busy), 0);

    // 4-byte read of host-loaded word, NACK on the last byte
    host_write(4'd1, 8'h11);
    host_write(4'd2, 8'h22);
    host_write(4'd3, 8'h33);
    host_write(4'd4, 8'h44);
    i2c_start();
    write_byte(8'hA1, ack);
    check("rd_addr_ack", 32'(ack), 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) check("rd_busy", 32'(bus.busy), 1);
      if (i == 2) host_write(4'd5, 8'h99);
      read_byte(rb, (i == 3));
      check("rd_byte", 32'(rb), 32'(rd4[i]));
    end
    wait_clk(Q);
    check("rd_release_after_nack", 32'(bus.sda_oe), 0);
    i2c_stop();
    wait_clk(4);
    check("rd_busy_after_stop", 32'(bus.busy), 0);

    // Address mismatch, then repeated START with the right address
    base_oe = oe_cnt;
    i2c_start();
    write_byte(8'hB0, ack);
    check("mis_nack",     32'(ack), 1);
    check("mis_no_drive", oe_cnt - base_oe, 0);
    check("mis_busy",     32'(bus.busy), 0);
    i2c_rstart();
    write_byte(8'hA0, ack);
    check("rs_ack",  32'(ack), 0);
    check("rs_busy", 32'(bus.busy), 1);
    i2c_stop();
    wait_clk(4);

    // Partial write is discarded; a fifth data byte is NACKed
    base_rxv = rxv_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h12, ack);
    write_byte(8'h34, ack);
    i2c_stop();
    wait_clk(4);
    check("part_no_rxvalid", rxv_cnt - base_rxv, 0);
    check("part_rxout_kept", bus.rxOut, 32'hDEADBEEF);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'hCA, ack);
    write_byte(8'hFE, ack);
    write_byte(8'hF0, ack);
    write_byte(8'h0D, ack);
    write_byte(8'h55, ack);
    check("wr_5th_nack", 32'(ack), 1);
    check("wr_rxout2",   bus.rxOut, 32'hCAFEF00D);
    i2c_stop();
    wait_clk(4);

    // Device address reprogrammed from the host port
    host_write(4'd0, 8'h21);
    i2c_start();
    write_byte(8'hA0, ack);
    check("old_addr_nack", 32'(ack), 1);
    i2c_rstart();
    write_byte(8'h42, ack);
    check("new_addr_ack", 32'(ack), 0);
    i2c_stop();
    wait_clk(4);

    // General call address
    i2c_start();
    write_byte(8'h00, ack);
`ifdef GENERAL_CALL_EN
    check("gc_ack",  32'(ack), 0);
    check("gc_flag", 32'(bus.genCall), 1);
    write_byte(8'h01, ack);
    write_byte(8'h02, ack);
    write_byte(8'h03, ack);
    write_byte(8'h04, ack);
    wait_clk(Q);
    check("gc_rxout", bus.rxOut, 32'h01020304);
    i2c_stop();
    wait_clk(4);
    check("gc_flag_after_stop", 32'(bus.genCall), 0);
`else
    check("gc_nack",     32'(ack), 1);
    check("gc_flag_off", 32'(bus.genCall), 0);
    i2c_stop();
    wait_clk(4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
